// File: rtl/calc_pkg.sv
// Shared types and constants for the UART calculator datapath.
package calc_pkg;

  localparam int unsigned CALC_RES_W = 33;
  localparam int unsigned MAG_W      = 36;
  localparam int unsigned NDIG_W     = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SIGN  = 3'd1,
    DIGIT = 3'd2,
    CR    = 3'd3,
    LF    = 3'd4
  } fmt_state_t;

  localparam logic [7:0] ASC_MINUS = 8'h2D;
  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_LF    = 8'h0A;
  localparam logic [7:0] ASC_ZERO  = 8'h30;
  localparam logic [7:0] ASC_A_UP  = 8'h41;
  localparam logic [7:0] ASC_A_LO  = 8'h61;

endpackage

// File: rtl/hex_to_ascii.sv
// Combinational nibble to ASCII hex character converter.
module hex_to_ascii
  import calc_pkg::*;
(
  input  logic [3:0] i_nib,
  input  logic       i_upper,
  output logic [7:0] o_ascii_c
);

  // Digits map from '0', letters from 'A' or 'a'
  always_comb begin
    o_ascii_c = ASC_ZERO + 8'(i_nib);
    if (i_nib > 4'd9) begin
      o_ascii_c = (i_upper ? ASC_A_UP : ASC_A_LO) + 8'(i_nib) - 8'd10;
    end
  end

endmodule

// File: rtl/calc_result_formatter.sv
// Formats each ALU result as a signed hex text line for the UART transmitter.
module calc_result_formatter
  import calc_pkg::*;
#(
  parameter bit EOL_CRLF  = 1'b1,
  parameter bit UPPERCASE = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_done,
  input  logic [CALC_RES_W-1:0] calc_res,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic                  fmt_done,
  output logic                  drop
);

  localparam int unsigned NIB_N = MAG_W / 4;

  fmt_state_t            r_state, w_state_nxt;
  logic [MAG_W-1:0]      r_mag, w_mag_nxt;
  logic [NDIG_W-1:0]     r_ndig, w_ndig_nxt;
  logic [7:0]            r_tx_data, w_tx_data_nxt;
  logic                  r_tx_valid;
  logic                  r_busy;
  logic                  r_fmt_done, w_fmt_done_nxt;
  logic                  r_drop;
  logic                  w_xfer;
  logic [CALC_RES_W-1:0] w_cap_abs;
  logic [MAG_W-1:0]      w_cap_mag;
  logic [NDIG_W-1:0]     w_cap_ndig;
  logic [NDIG_W-1:0]     w_dig_idx;
  logic [3:0]            w_nib;
  logic [7:0]            w_dig_ascii;

  assign w_xfer    = r_tx_valid & tx_ready;

  // Magnitude of the incoming result; -2^32 maps to 0x1_0000_0000
  assign w_cap_abs = calc_res[CALC_RES_W-1] ? (CALC_RES_W'(0) - calc_res) : calc_res;
  assign w_cap_mag = MAG_W'(w_cap_abs);

  // Leading-zero priority encoder: count of significant nibbles, minimum 1
  always_comb begin
    w_cap_ndig = NDIG_W'(1);
    for (int unsigned i = 0; i < NIB_N; i++) begin
      if (w_cap_mag[4*i +: 4] != 4'd0) begin
        w_cap_ndig = NDIG_W'(i + 1);
      end
    end
  end

  // Next-state logic, digit down-counter and done pulse
  always_comb begin
    w_state_nxt    = r_state;
    w_mag_nxt      = r_mag;
    w_ndig_nxt     = r_ndig;
    w_fmt_done_nxt = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (alu_done) begin
          w_mag_nxt   = w_cap_mag;
          w_ndig_nxt  = w_cap_ndig;
          w_state_nxt = calc_res[CALC_RES_W-1] ? SIGN : DIGIT;
        end
      end
      SIGN: begin
        if (w_xfer) w_state_nxt = DIGIT;
      end
      DIGIT: begin
        if (w_xfer) begin
          if (r_ndig == NDIG_W'(1)) begin
            w_state_nxt = EOL_CRLF ? CR : LF;
          end else begin
            w_ndig_nxt = r_ndig - NDIG_W'(1);
          end
        end
      end
      CR: begin
        if (w_xfer) w_state_nxt = LF;
      end
      LF: begin
        if (w_xfer) begin
          w_state_nxt    = IDLE;
          w_fmt_done_nxt = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Current digit of the line being entered, selected from the next-cycle counter
  assign w_dig_idx = w_ndig_nxt - NDIG_W'(1);
  assign w_nib     = 4'(w_mag_nxt >> {w_dig_idx, 2'b00});

  hex_to_ascii u_hex_to_ascii (
    .i_nib     (w_nib),
    .i_upper   (UPPERCASE),
    .o_ascii_c (w_dig_ascii)
  );

  // Byte offered in the state being entered; holds while the state holds
  always_comb begin
    w_tx_data_nxt = 8'h00;
    unique case (w_state_nxt)
      SIGN:    w_tx_data_nxt = ASC_MINUS;
      DIGIT:   w_tx_data_nxt = w_dig_ascii;
      CR:      w_tx_data_nxt = ASC_CR;
      LF:      w_tx_data_nxt = ASC_LF;
      default: w_tx_data_nxt = 8'h00;
    endcase
  end

  // State, counter and handshake output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_mag      <= '0;
      r_ndig     <= '0;
      r_tx_data  <= 8'h00;
      r_tx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_fmt_done <= 1'b0;
      r_drop     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_mag      <= w_mag_nxt;
      r_ndig     <= w_ndig_nxt;
      r_tx_data  <= w_tx_data_nxt;
      r_tx_valid <= (w_state_nxt != IDLE);
      r_busy     <= (w_state_nxt != IDLE);
      r_fmt_done <= w_fmt_done_nxt;
      r_drop     <= alu_done & (r_state != IDLE);
    end
  end

  assign tx_data  = r_tx_data;
  assign tx_valid = r_tx_valid;
  assign busy     = r_busy;
  assign fmt_done = r_fmt_done;
  assign drop     = r_drop;

endmodule

// File: tb/tb_calc_result_formatter.sv
// Bench for calc_result_formatter: three parameter variants share the stimulus.
module tb_calc_result_formatter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_done;
  logic [32:0] calc_res;
  logic        tx_ready;

  // Variant 0: CRLF/upper, 1: CRLF/lower, 2: LF/upper
  logic [7:0] d0, d1, d2;
  logic       v0, v1, v2, b0, b1, b2, f0, f1, f2, dr0, dr1, dr2;

  int n_chk  = 0;
  int n_fail = 0;

  logic [95:0] cap [3];
  int          len [3];

  calc_result_formatter #(.EOL_CRLF(1'b1), .UPPERCASE(1'b1)) u_dut0 (
    .clk(clk), .rst(rst), .alu_done(alu_done), .calc_res(calc_res),
    .tx_data(d0), .tx_valid(v0), .tx_ready(tx_ready),
    .busy(b0), .fmt_done(f0), .drop(dr0));

  calc_result_formatter #(.EOL_CRLF(1'b1), .UPPERCASE(1'b0)) u_dut1 (
    .clk(clk), .rst(rst), .alu_done(alu_done), .calc_res(calc_res),
    .tx_data(d1), .tx_valid(v1), .tx_ready(tx_ready),
    .busy(b1), .fmt_done(f1), .drop(dr1));

  calc_result_formatter #(.EOL_CRLF(1'b0), .UPPERCASE(1'b1)) u_dut2 (
    .clk(clk), .rst(rst), .alu_done(alu_done), .calc_res(calc_res),
    .tx_data(d2), .tx_valid(v2), .tx_ready(tx_ready),
    .busy(b2), .fmt_done(f2), .drop(dr2));

  always #5 clk = ~clk;

  // Record every byte that will transfer at the coming rising edge
  always @(negedge clk) begin
    if (v0 && tx_ready) begin cap[0] = {cap[0][87:0], d0}; len[0]++; end
    if (v1 && tx_ready) begin cap[1] = {cap[1][87:0], d1}; len[1]++; end
    if (v2 && tx_ready) begin cap[2] = {cap[2][87:0], d2}; len[2]++; end
  end

  // Reference text of one line, built from the signed value with string formatting
  function automatic string model_line(input logic [32:0] res, input bit crlf, input bit upper);
    longint s, m;
    string  h, line;
    s = longint'(res);
    if (res[32]) s = s - (longint'(1) <<< 33);
    m = (s < 0) ? -s : s;
    h = $sformatf("%0h", m);
    if (upper) h = h.toupper();
    if (s < 0) line = {"-", h};
    else       line = h;
    if (crlf) line = {line, "\r\n"};
    else      line = {line, "\n"};
    return line;
  endfunction

  function automatic logic [95:0] pack(input string s);
    logic [95:0] v = '0;
    for (int i = 0; i < s.len(); i++) v = {v[87:0], s[i]};
    return v;
  endfunction

  task automatic clear_caps();
    for (int k = 0; k < 3; k++) begin cap[k] = '0; len[k] = 0; end
  endtask

  task automatic pulse(input logic [32:0] res);
    calc_res = res;
    alu_done = 1'b1;
    @(posedge clk); #1;
    alu_done = 1'b0;
  endtask

  task automatic wait_idle(input bit rnd, output bit to);
    int c = 0;
    while ((b0 || b1 || b2) && c < 400) begin
      tx_ready = rnd ? ($urandom_range(0, 99) >= 40) : 1'b1;
      @(posedge clk); #1;
      c++;
    end
    to = b0 | b1 | b2;
    tx_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; alu_done = 1'b0; calc_res = '0; tx_ready = 1'b0;
    clear_caps();
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if ({d0, v0, b0, f0, dr0, d1, v1, b1, f1, dr1, d2, v2, b2, f2, dr2} !== '0) begin
      $display("FAIL reset_values: got d=%h/%h/%h v=%b%b%b busy=%b%b%b done=%b%b%b drop=%b%b%b, expected all zero",
               d0, d1, d2, v0, v1, v2, b0, b1, b2, f0, f1, f2, dr0, dr1, dr2);
      n_fail++;
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_chk++;
    if ({v0, b0, v1, b1, v2, b2} !== 6'b0) begin
      $display("FAIL idle_after_reset: got valid/busy=%b%b %b%b %b%b, expected 0", v0, b0, v1, b1, v2, b2);
      n_fail++;
    end
  endtask

  task automatic test_two_digit();
    logic [7:0] e [4] = '{8'h31, 8'h32, 8'h0D, 8'h0A};
    bit         to;
    string      exp;
    tx_ready = 1'b1;
    clear_caps();
    pulse(33'h0_0000_0012);
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (v0 !== 1'b1 || d0 !== e[i]) begin
        $display("FAIL two_digit_byte%0d: got valid=%b data=%h, expected valid=1 data=%h", i, v0, d0, e[i]);
        n_fail++;
      end
      @(posedge clk); #1;
    end
    n_chk++;
    if (f0 !== 1'b1 || b0 !== 1'b0 || v0 !== 1'b0) begin
      $display("FAIL two_digit_done: got fmt_done=%b busy=%b valid=%b, expected 1 0 0", f0, b0, v0);
      n_fail++;
    end
    @(posedge clk); #1;
    n_chk++;
    if (f0 !== 1'b0) begin
      $display("FAIL two_digit_done_width: got fmt_done=%b, expected 0", f0);
      n_fail++;
    end
    wait_idle(1'b0, to);
    for (int k = 0; k < 3; k++) begin
      exp = model_line(33'h12, k != 2, k != 1);
      n_chk++;
      if (len[k] != exp.len() || cap[k] !== pack(exp)) begin
        $display("FAIL two_digit_line dut%0d: got len=%0d bytes=%h, expected len=%0d bytes=%h",
                 k, len[k], cap[k], exp.len(), pack(exp));
        n_fail++;
      end
    end
  endtask

  task automatic test_directed_lines();
    logic [32:0] vals [6] = '{33'h0_0000_0000, 33'h1_FFFF_FFF9, 33'h1_0000_0000,
                             33'h0_FFFF_FFFF, 33'h0_0000_0ABC, 33'h1_0000_0001};
    bit          to;
    string       exp;
    for (int i = 0; i < 6; i++) begin
      clear_caps();
      tx_ready = 1'b1;
      pulse(vals[i]);
      wait_idle(1'b0, to);
      n_chk++;
      if (to) begin
        $display("FAIL directed_timeout res=%h: got busy=%b%b%b, expected idle", vals[i], b0, b1, b2);
        n_fail++;
      end
      for (int k = 0; k < 3; k++) begin
        exp = model_line(vals[i], k != 2, k != 1);
        n_chk++;
        if (len[k] != exp.len() || cap[k] !== pack(exp)) begin
          $display("FAIL directed_line dut%0d res=%h: got len=%0d bytes=%h, expected len=%0d bytes=%h",
                   k, vals[i], len[k], cap[k], exp.len(), pack(exp));
          n_fail++;
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    logic       pv, pr;
    logic [7:0] pd;
    int         cyc = 0;
    string      exp;
    clear_caps();
    tx_ready = 1'b0;
    pulse(33'h0_0000_ABCD);
    pv = 1'b0; pr = 1'b1; pd = 8'h00;
    while ((b0 || b1 || b2) && cyc < 300) begin
      if (pv && !pr) begin
        n_chk++;
        if (v0 !== 1'b1 || d0 !== pd) begin
          $display("FAIL backpressure_hold cycle%0d: got valid=%b data=%h, expected valid=1 data=%h", cyc, v0, d0, pd);
          n_fail++;
        end
      end
      pv = v0; pd = d0;
      tx_ready = ($urandom_range(0, 99) >= 40);
      pr = tx_ready;
      @(posedge clk); #1;
      cyc++;
    end
    tx_ready = 1'b1;
    n_chk++;
    if (b0 || b1 || b2) begin
      $display("FAIL backpressure_timeout: got busy=%b%b%b, expected idle", b0, b1, b2);
      n_fail++;
    end
    for (int k = 0; k < 3; k++) begin
      exp = model_line(33'hABCD, k != 2, k != 1);
      n_chk++;
      if (len[k] != exp.len() || cap[k] !== pack(exp)) begin
        $display("FAIL backpressure_line dut%0d: got len=%0d bytes=%h, expected len=%0d bytes=%h",
                 k, len[k], cap[k], exp.len(), pack(exp));
        n_fail++;
      end
    end
  endtask

  task automatic test_random_lines();
    logic [32:0] val;
    bit          to;
    string       exp;
    for (int i = 0; i < 25; i++) begin
      case ($urandom_range(0, 3))
        0:       val = 33'($urandom_range(0, 255));
        1:       val = 33'(0) - 33'($urandom_range(1, 4096));
        default: val = {1'($urandom), 32'($urandom)};
      endcase
      clear_caps();
      tx_ready = 1'($urandom);
      pulse(val);
      wait_idle(1'b1, to);
      n_chk++;
      if (to) begin
        $display("FAIL random_timeout res=%h: got busy=%b%b%b, expected idle", val, b0, b1, b2);
        n_fail++;
      end
      for (int k = 0; k < 3; k++) begin
        exp = model_line(val, k != 2, k != 1);
        n_chk++;
        if (len[k] != exp.len() || cap[k] !== pack(exp)) begin
          $display("FAIL random_line dut%0d res=%h: got len=%0d bytes=%h, expected len=%0d bytes=%h",
                   k, val, len[k], cap[k], exp.len(), pack(exp));
          n_fail++;
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_drop();
    bit    to;
    string exp;
    clear_caps();
    tx_ready = 1'b1;
    pulse(33'h0_0000_ABCD);
    @(posedge clk); #1;
    pulse(33'h0_0000_0005);
    n_chk++;
    if ({dr0, dr1, dr2} !== 3'b111) begin
      $display("FAIL drop_pulse: got drop=%b%b%b, expected 111", dr0, dr1, dr2);
      n_fail++;
    end
    @(posedge clk); #1;
    n_chk++;
    if ({dr0, dr1, dr2} !== 3'b000) begin
      $display("FAIL drop_width: got drop=%b%b%b, expected 000", dr0, dr1, dr2);
      n_fail++;
    end
    wait_idle(1'b0, to);
    repeat (4) @(posedge clk);
    #1;
    n_chk++;
    if (to || b0 || b1 || b2) begin
      $display("FAIL drop_idle: got busy=%b%b%b, expected 000", b0, b1, b2);
      n_fail++;
    end
    for (int k = 0; k < 3; k++) begin
      exp = model_line(33'hABCD, k != 2, k != 1);
      n_chk++;
      if (len[k] != exp.len() || cap[k] !== pack(exp)) begin
        $display("FAIL drop_line dut%0d: got len=%0d bytes=%h, expected len=%0d bytes=%h",
                 k, len[k], cap[k], exp.len(), pack(exp));
        n_fail++;
      end
    end
  endtask

  task automatic test_fmt_done_collision();
    bit    to;
    int    c;
    string exp;
    clear_caps();
    tx_ready = 1'b1;
    pulse(33'h0_0000_0012);
    c = 0;
    while (f0 !== 1'b1 && c < 20) begin
      @(posedge clk); #1;
      c++;
    end
    n_chk++;
    if (f0 !== 1'b1 || len[0] != 4 || cap[0] !== pack(model_line(33'h12, 1'b1, 1'b1))) begin
      $display("FAIL collision_first_line: got fmt_done=%b len=%0d bytes=%h, expected 1 len=4 bytes=%h",
               f0, len[0], cap[0], pack(model_line(33'h12, 1'b1, 1'b1)));
      n_fail++;
    end
    clear_caps();
    pulse(33'h0_0000_0003);
    n_chk++;
    if (v0 !== 1'b1 || d0 !== 8'h33 || b0 !== 1'b1) begin
      $display("FAIL collision_capture: got valid=%b data=%h busy=%b, expected 1 33 1", v0, d0, b0);
      n_fail++;
    end
    wait_idle(1'b0, to);
    for (int k = 0; k < 3; k++) begin
      exp = model_line(33'h3, k != 2, k != 1);
      n_chk++;
      if (to || len[k] != exp.len() || cap[k] !== pack(exp)) begin
        $display("FAIL collision_second_line dut%0d: got len=%0d bytes=%h, expected len=%0d bytes=%h",
                 k, len[k], cap[k], exp.len(), pack(exp));
        n_fail++;
      end
    end
  endtask

  task automatic test_reset_midline();
    bit    to;
    string exp;
    clear_caps();
    tx_ready = 1'b1;
    pulse(33'h1_FFFF_EDCC);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    n_chk++;
    if ({d0, v0, b0, f0, dr0, d1, v1, b1, d2, v2, b2} !== '0) begin
      $display("FAIL reset_midline_outputs: got d=%h/%h/%h v=%b%b%b busy=%b%b%b, expected all zero",
               d0, d1, d2, v0, v1, v2, b0, b1, b2);
      n_fail++;
    end
    n_chk++;
    if (len[0] != 2 || cap[0] !== 96'h2D31) begin
      $display("FAIL reset_midline_partial: got len=%0d bytes=%h, expected len=2 bytes=2d31", len[0], cap[0]);
      n_fail++;
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    clear_caps();
    pulse(33'h0_0000_0009);
    wait_idle(1'b0, to);
    for (int k = 0; k < 3; k++) begin
      exp = model_line(33'h9, k != 2, k != 1);
      n_chk++;
      if (to || len[k] != exp.len() || cap[k] !== pack(exp)) begin
        $display("FAIL reset_midline_next_line dut%0d: got len=%0d bytes=%h, expected len=%0d bytes=%h",
                 k, len[k], cap[k], exp.len(), pack(exp));
        n_fail++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_two_digit();
    test_directed_lines();
    test_backpressure();
    test_random_lines();
    test_drop();
    test_fmt_done_collision();
    test_reset_midline();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/calc_result_formatter.md
# calc_result_formatter

Converts each ALU result of the UART calculator into an ASCII text line for the UART transmitter. It sits between the ALU (`calc_res`/`alu_done`) and the UART TX byte interface, and it is the output-side counterpart of the parser that feeds the ALU. Each result becomes an optional minus sign, then the magnitude as hex digits with leading zeros suppressed, then an end-of-line sequence. Bytes are handed to the transmitter over a valid/ready handshake.

## Interface
- `EOL_CRLF`, default 1. 1 means the line ends with CR LF (0x0D 0x0A); 0 means LF only.
- `UPPERCASE`, default 1. 1 means hex letters are 'A'–'F'; 0 means 'a'–'f'.
- `clk`  in  1  — the single clock; all logic on the rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `alu_done`  in  1  — one-cycle pulse; `calc_res` is valid in that cycle.
- `calc_res`  in  33  — ALU result, 33-bit two's complement.
- `tx_data`  out  8  — ASCII byte offered to the UART TX.
- `tx_valid`  out  1  — `tx_data` is valid.
- `tx_ready`  in  1  — the UART TX accepts the byte this cycle.
- `busy`  out  1  — a line is being emitted.
- `fmt_done`  out  1  — one-cycle pulse after the last byte of a line is accepted.
- `drop`  out  1  — one-cycle pulse when an `alu_done` arrives while busy and is discarded.

## Operation
- **Reset values:** `tx_data`=0x00, `tx_valid`=0, `busy`=0, `fmt_done`=0, `drop`=0, state IDLE. Reset clears all internal registers.
- **States:** IDLE, SIGN, DIGIT, CR, LF.
- **Capture (IDLE with `alu_done`=1):**
  - `neg` = `calc_res[32]`.
  - `mag` = |`calc_res`| as a 33-bit unsigned value, zero-extended to 36 bits (9 nibbles). -2^32 gives `mag`=0x1_0000_0000.
  - `ndig` = index of the most significant non-zero nibble + 1, range 1..9. `mag`=0 gives `ndig`=1.
- **Next state after capture:** SIGN if `neg`=1, else DIGIT.
- **SIGN:** offers 0x2D ('-'). On transfer, go to DIGIT.
- **DIGIT:** offers nibble `ndig`-1 of `mag`.
  - 0–9 map to 0x30–0x39.
  - 10–15 map to 0x41–0x46, or 0x61–0x66 when `UPPERCASE`=0.
  - On each transfer, decrement `ndig`. After the transfer with `ndig`=1, go to CR if `EOL_CRLF`=1, else LF.
- **CR:** offers 0x0D. On transfer, go to LF.
- **LF:** offers 0x0A. On transfer, go to IDLE and pulse `fmt_done`.
- **Transfer rule:** a transfer happens at a rising edge where `tx_valid`=1 and `tx_ready`=1.
- **`tx_valid`:** 1 in SIGN, DIGIT, CR and LF; 0 in IDLE. Once `tx_valid` is high, it and `tx_data` hold unchanged until a transfer.
- **`busy`:** 1 in every state except IDLE.
- **`alu_done` while `busy`=1:** the result is discarded, `drop` pulses for one cycle, and the current line is unaffected.
- **`alu_done` in the cycle where `fmt_done`=1:** state is already IDLE, so the result is captured normally.
- **Reset mid-line:** the partial line is abandoned and outputs go to their reset values immediately. The TX side sees `tx_valid` fall without a transfer, and no CR/LF is sent.

## Timing
- **Latency:** `alu_done` sampled at edge N gives `tx_valid`=1 with the first byte from edge N onward (registered outputs, visible in cycle N+1).
- **Throughput:** with `tx_ready` held high, one byte per cycle, with no bubbles between bytes of a line.
- **Line length:** `neg` + `ndig` + (`EOL_CRLF` ? 2 : 1) bytes, at most 12.
- **`fmt_done`:** asserted in the cycle after the edge that transfers LF, for exactly one cycle. `busy` is 0 in that cycle.
- **Minimum spacing between lines:** one idle cycle between the LF transfer and the first byte of the next line.
- **`drop`:** registered, high in the cycle after the discarded `alu_done`.

## Structure
- **Shared package `calc_pkg`:**
  - `CALC_RES_W`=33.
  - The FSM state typedef `fmt_state_t`.
  - ASCII constants `ASC_MINUS`, `ASC_CR`, `ASC_LF`, `ASC_ZERO`, `ASC_A_UP`, `ASC_A_LO`.
- **Sub-module `hex_to_ascii`:** combinational, 4-bit nibble plus `UPPERCASE` in, 8-bit ASCII out. It is reusable by other debug/echo paths.
- **Top level:** capture and magnitude logic, the leading-zero priority encoder, the digit down-counter, the FSM, and the handshake registers.

## Test plan
- **Positive two-digit result:** `calc_res`=0x0_0000_0012 with `tx_ready`=1 → 0x31 0x32 0x0D 0x0A on 4 consecutive cycles, then `fmt_done` for one cycle.
- **Zero and small negative:**
  - `calc_res`=0 → 0x30 0x0D 0x0A.
  - `calc_res`=0x1_FFFF_FFF9 (-7) → 0x2D 0x37 0x0D 0x0A.
- **Extremes:**
  - `calc_res`=0x1_0000_0000 → "-100000000\r\n" (12 bytes).
  - `calc_res`=0x0_FFFF_FFFF → "FFFFFFFF\r\n"; with `UPPERCASE`=0 → "ffffffff\r\n"; with `EOL_CRLF`=0 → LF only.
- **Backpressure:** random `tx_ready` (≥30% low) on 0x0_0000_ABCD → `tx_data`/`tx_valid` stable while not ready, exact byte sequence 'A' 'B' 'C' 'D' CR LF.
- **Collisions:**
  - `alu_done` with 0x5 two cycles into an active line → `drop` pulses and the line output is unchanged.
  - `alu_done` in the `fmt_done` cycle → the next line is emitted.
- **Reset mid-line:** assert `rst` after 2 bytes of "-1234\r\n" → outputs immediately 0. After release, `calc_res`=0x9 → clean "9\r\n".
